ttt_game_core: RTL and testbench
================================

TTT_GAME_CORE -- requirements
Module: ttt_game_core

Interface
REQ-001 Parameter N, default 3, board is N x N cells (legal 3..8).
REQ-002 Parameter K, default 3, stones in a line needed to win (legal 3..N).
REQ-003 Parameter FIRST, default 1, player code that moves first after reset/new game (1 or 2).
REQ-004 Derived: RW = clog2(N) coordinate width; CW = clog2(N*N+1) count width.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 new_game  input  1  one-cycle request to clear board and restart.
REQ-008 move_valid  input  1  move request qualifier, sampled only on clk edge.
REQ-009 move_row  input  RW  row of requested cell.
REQ-010 move_col  input  RW  column of requested cell.
REQ-011 move_ready  output  1  high when a move can be accepted.
REQ-012 move_err  output  1  one-cycle pulse on rejected move.
REQ-013 cur_player  output  2  player to move (01 or 10).
REQ-014 status  output  2  00 PLAYING, 01 WIN, 10 DRAW.
REQ-015 winner  output  2  winning player code, 00 unless status=WIN.
REQ-016 move_count  output  CW  stones on board.
REQ-017 rd_row, rd_col  input  RW each  board read address.
REQ-018 rd_cell  output  2  cell contents: 00 empty, 01 player1, 10 player2.

Function
REQ-019 States: WAIT (move_ready=1), CHECK (move_ready=0), OVER (move_ready=0); move_ready is registered and equals (state==WAIT).
REQ-020 Move accepted when move_valid=1, state=WAIT, move_row<N, move_col<N, target cell empty; next edge writes cur_player into cell, increments move_count, enters CHECK.
REQ-021 Move rejected when move_valid=1 and any acceptance condition fails (out of range, occupied, CHECK, OVER): move_err=1 next cycle for exactly one cycle, no state, board, player or count change.
REQ-022 CHECK lasts exactly 8*(K-1) cycles: directions horizontal, vertical, diagonal, anti-diagonal in that order; per direction K-1 cycles stepping + side then K-1 cycles stepping - side, one cell per cycle from last move.
REQ-023 Per side, run length stops incrementing at first off-board cell or cell not equal to mover; later steps that side add nothing.
REQ-024 Line length = 1 + plus-run + minus-run; any direction with length >= K flags win.
REQ-025 On CHECK exit: win -> OVER, status=WIN, winner=mover; else move_count==N*N -> OVER, status=DRAW; else WAIT with cur_player toggled (01<->10).
REQ-026 Win on final cell reports WIN, never DRAW.
REQ-027 Status/winner/cur_player update on the same edge that leaves CHECK; move_ready=1 on that edge only if entering WAIT.
REQ-028 new_game=1: next edge clears all cells, move_count=0, status=00, winner=00, cur_player=FIRST, state WAIT, move_err=0; valid from any state, aborts CHECK.
REQ-029 new_game and move_valid in same cycle: new_game wins, move ignored, no move_err.
REQ-030 rd_cell registered: shows cell(rd_row, rd_col) one cycle after address; out-of-range address returns 00; a write and read of the same cell in one cycle returns the old value.
REQ-031 move_count saturates at N*N; never wraps.

Reset
REQ-032 rst has priority over all inputs and produces exactly the new_game state of REQ-028; rd_cell=00.
REQ-033 rst asserted mid-CHECK aborts check; no status update follows.

Verification
REQ-034 N=3,K=3: P1 (0,0),(1,1),(2,2) interleaved with P2 (0,1),(0,2) -> after third P1 move, 16 cycles in CHECK then status=01, winner=01, move_count=5, move_ready=0.
REQ-035 N=3: move to occupied (1,1), then move_row=3 -> move_err one-cycle pulse each, move_count and cur_player unchanged, rd_cell(1,1) unchanged.
REQ-036 N=3: 9-move no-line sequence (X O X / X O O / O X X) -> status=10, winner=00, move_count=9; further move_valid -> move_err.
REQ-037 N=5,K=4: P1 anti-diagonal (0,3),(1,2),(2,1),(3,0), 4th stone placed last in the middle position (1,2) -> WIN after 24 CHECK cycles; 3 in a row alone -> PLAYING.
REQ-038 Assert new_game two cycles into CHECK with move_valid also high -> board all 00, cur_player=FIRST, status=00, no move_err, move_ready=1 next cycle.
REQ-039 Assert rst during OVER with FIRST=2 -> all cells 00, cur_player=10, move_count=0, status=00, move_ready=1.

Source files
------------

// File: rtl/ttt_game_core.sv
// ttt_game_core: N x N game board with move arbitration and a serial K-in-a-row win checker.
module ttt_game_core #(
  parameter int N = 3,
  parameter int K = 3,
  parameter int FIRST = 1,
  localparam int RW = $clog2(N),
  localparam int CW = $clog2(N * N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic          move_valid,
  input  logic [RW-1:0] move_row,
  input  logic [RW-1:0] move_col,
  output logic          move_ready,
  output logic          move_err,
  output logic [1:0]    cur_player,
  output logic [1:0]    status,
  output logic [1:0]    winner,
  output logic [CW-1:0] move_count,
  input  logic [RW-1:0] rd_row,
  input  logic [RW-1:0] rd_col,
  output logic [1:0]    rd_cell
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int SW = $clog2(K);
  typedef enum logic [1:0] {WAIT, CHECK, OVER} state_t;
  state_t state_q, state_d;
  logic [NN-1:0][1:0] board_q, board_d;
  logic [1:0] cur_q, cur_d, status_q, status_d, winner_q, winner_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic err_q, err_d;
  logic [RW-1:0] lr_q, lr_d, lc_q, lc_d;
  logic [1:0] dir_q, dir_d;
  logic side_q, side_d, alive_q, alive_d, win_q, win_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0] len_q, len_d, len_n;
  logic signed [5:0] dr, dc, off, pr, pc;
  logic [IW-1:0] mv_idx, rd_idx, pr_idx;
  logic mv_ok, rd_ok, hit, accept, win_n;
  always_comb begin
    mv_ok = 32'(move_row) < N && 32'(move_col) < N;
    rd_ok = 32'(rd_row) < N && 32'(rd_col) < N;
    mv_idx = IW'(32'(move_row) * N + 32'(move_col));
    rd_idx = IW'(32'(rd_row) * N + 32'(rd_col));
    dr = (dir_q == 2'd0) ? 6'sd0 : 6'sd1;
    dc = (dir_q == 2'd1) ? 6'sd0 : (dir_q == 2'd3) ? -6'sd1 : 6'sd1;
    off = $signed(6'(step_q)) + 6'sd1;
    pr = side_q ? $signed(6'(lr_q)) - dr * off : $signed(6'(lr_q)) + dr * off;
    pc = side_q ? $signed(6'(lc_q)) - dc * off : $signed(6'(lc_q)) + dc * off;
    pr_idx = IW'(32'(pr) * N + 32'(pc));
    // probe cell counts only while on the board and owned by the mover
    hit = !pr[5] && !pc[5] && 32'(pr) < N && 32'(pc) < N && board_q[pr_idx] == cur_q;
    accept = move_valid && state_q == WAIT && mv_ok && board_q[mv_idx] == 2'b00;
    len_n = len_q + 4'(alive_q && hit);
    win_n = win_q || (side_q && len_n >= 4'(K));
    state_d = state_q;
    board_d = board_q;
    cur_d = cur_q;
    status_d = status_q;
    winner_d = winner_q;
    count_d = count_q;
    err_d = 1'b0;
    rd_d = rd_ok ? board_q[rd_idx] : 2'b00;
    lr_d = lr_q;
    lc_d = lc_q;
    dir_d = dir_q;
    side_d = side_q;
    alive_d = alive_q;
    win_d = win_q;
    step_d = step_q;
    len_d = len_q;
    if (new_game) begin
      state_d = WAIT;
      board_d = '0;
      cur_d = 2'(FIRST);
      status_d = 2'b00;
      winner_d = 2'b00;
      count_d = '0;
    end else if (state_q == WAIT) begin
      if (accept) begin
        board_d[mv_idx] = cur_q;
        count_d = count_q + CW'(count_q != CW'(NN));
        lr_d = move_row;
        lc_d = move_col;
        state_d = CHECK;
        dir_d = 2'd0;
        side_d = 1'b0;
        step_d = '0;
        alive_d = 1'b1;
        len_d = 4'd1;
        win_d = 1'b0;
      end else begin
        err_d = move_valid;
      end
    end else if (state_q == CHECK) begin
      err_d = move_valid;
      alive_d = alive_q && hit;
      len_d = len_n;
      step_d = step_q + SW'(1);
      if (step_q == SW'(K - 2)) begin
        step_d = '0;
        alive_d = 1'b1;
        side_d = !side_q;
        dir_d = side_q ? dir_q + 2'd1 : dir_q;
        len_d = side_q ? 4'd1 : len_n;
        win_d = win_n;
        if (side_q && dir_q == 2'd3) begin
          state_d = (win_n || count_q == CW'(NN)) ? OVER : WAIT;
          status_d = win_n ? 2'b01 : (count_q == CW'(NN)) ? 2'b10 : 2'b00;
          winner_d = win_n ? cur_q : 2'b00;
          cur_d = (win_n || count_q == CW'(NN)) ? cur_q : cur_q ^ 2'b11;
        end
      end
    end else begin
      err_d = move_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      board_q <= '0;
      cur_q <= 2'(FIRST);
      status_q <= 2'b00;
      winner_q <= 2'b00;
      count_q <= '0;
      err_q <= 1'b0;
      rd_q <= 2'b00;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      cur_q <= cur_d;
      status_q <= status_d;
      winner_q <= winner_d;
      count_q <= count_d;
      err_q <= err_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    lr_q <= lr_d;
    lc_q <= lc_d;
    dir_q <= dir_d;
    side_q <= side_d;
    alive_q <= alive_d;
    win_q <= win_d;
    step_q <= step_d;
    len_q <= len_d;
  end
  assign move_ready = state_q == WAIT;
  assign move_err = err_q;
  assign cur_player = cur_q;
  assign status = status_q;
  assign winner = winner_q;
  assign move_count = count_q;
  assign rd_cell = rd_q;
endmodule

// File: tb/tb_ttt_game_core.sv
// tb_ttt_game_core: two instances (3x3/K3/FIRST1 and 5x5/K4/FIRST2) checked every cycle against a rule-level game model.
module tb_ttt_game_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2];
  logic ng [2];
  logic mv [2];
  logic [2:0] mr [2];
  logic [2:0] mc [2];
  logic [2:0] rr [2];
  logic [2:0] rc [2];
  logic rdy [2];
  logic er [2];
  logic [1:0] cur [2];
  logic [1:0] st [2];
  logic [1:0] wn [2];
  logic [1:0] rdc [2];
  logic [3:0] cnt_a;
  logic [4:0] cnt_b;
  int checks = 0, fails = 0;
  bit chk_en = 0;
  int mb [2][8][8];
  int mcur [2], mst [2], mwn [2], mcnt [2], mrdy [2], merr [2], mrd [2], mcd [2], mpw [2], mover [2];
  ttt_game_core #(.N(3), .K(3), .FIRST(1)) dut_a (
    .clk(clk), .rst(rst[0]), .new_game(ng[0]), .move_valid(mv[0]),
    .move_row(mr[0][1:0]), .move_col(mc[0][1:0]), .move_ready(rdy[0]), .move_err(er[0]),
    .cur_player(cur[0]), .status(st[0]), .winner(wn[0]), .move_count(cnt_a),
    .rd_row(rr[0][1:0]), .rd_col(rc[0][1:0]), .rd_cell(rdc[0]));
  ttt_game_core #(.N(5), .K(4), .FIRST(2)) dut_b (
    .clk(clk), .rst(rst[1]), .new_game(ng[1]), .move_valid(mv[1]),
    .move_row(mr[1]), .move_col(mc[1]), .move_ready(rdy[1]), .move_err(er[1]),
    .cur_player(cur[1]), .status(st[1]), .winner(wn[1]), .move_count(cnt_b),
    .rd_row(rr[1]), .rd_col(rc[1]), .rd_cell(rdc[1]));
  function automatic int nn(int i); return i == 0 ? 3 : 5; endfunction
  function automatic int kk(int i); return i == 0 ? 3 : 4; endfunction
  function automatic int ff(int i); return i == 0 ? 1 : 2; endfunction
  function automatic logic [4:0] cnt(int i); return i == 0 ? {1'b0, cnt_a} : cnt_b; endfunction
  function automatic int line_win(int i, int r, int c, int p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int len = 1;
      for (int s = -1; s <= 1; s += 2) begin
        int y = r + s * dr[d], x = c + s * dc[d];
        while (y >= 0 && y < nn(i) && x >= 0 && x < nn(i) && mb[i][y][x] == p) begin
          len++;
          y += s * dr[d];
          x += s * dc[d];
        end
      end
      if (len >= kk(i)) return 1;
    end
    return 0;
  endfunction
  task automatic model_step(int i);
    int n = nn(i);
    int rdn = (rr[i] < n && rc[i] < n) ? mb[i][rr[i]][rc[i]] : 0;
    if (rst[i] || ng[i]) begin
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mb[i][r][c] = 0;
      mcur[i] = ff(i); mst[i] = 0; mwn[i] = 0; mcnt[i] = 0; mrdy[i] = 1;
      mcd[i] = 0; mover[i] = 0; merr[i] = 0; mrd[i] = rst[i] ? 0 : rdn;
    end else begin
      merr[i] = 0;
      if (mcd[i] > 0) begin
        merr[i] = int'(mv[i]);
        mcd[i]--;
        if (mcd[i] == 0) begin
          if (mpw[i] != 0) begin mover[i] = 1; mst[i] = 1; mwn[i] = mcur[i]; end
          else if (mcnt[i] == n * n) begin mover[i] = 1; mst[i] = 2; end
          else begin mcur[i] = 3 - mcur[i]; mrdy[i] = 1; end
        end
      end else if (mover[i] != 0) begin
        merr[i] = int'(mv[i]);
      end else if (mv[i]) begin
        if (mr[i] < n && mc[i] < n && mb[i][mr[i]][mc[i]] == 0) begin
          mb[i][mr[i]][mc[i]] = mcur[i];
          mcnt[i]++;
          mpw[i] = line_win(i, int'(mr[i]), int'(mc[i]), mcur[i]);
          mcd[i] = 8 * (kk(i) - 1);
          mrdy[i] = 0;
        end else merr[i] = 1;
      end
      mrd[i] = rdn;
    end
  endtask
  always @(posedge clk) for (int i = 0; i < 2; i++) model_step(i);
  task automatic chk(string nm, int i, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] at %0t: got %0d required %0d", nm, i, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) for (int i = 0; i < 2; i++) begin
    chk("ready", i, 8'(rdy[i]), 8'(mrdy[i]));
    chk("err", i, 8'(er[i]), 8'(merr[i]));
    chk("cur_player", i, 8'(cur[i]), 8'(mcur[i]));
    chk("status", i, 8'(st[i]), 8'(mst[i]));
    chk("winner", i, 8'(wn[i]), 8'(mwn[i]));
    chk("move_count", i, 8'(cnt(i)), 8'(mcnt[i]));
    chk("rd_cell", i, 8'(rdc[i]), 8'(mrd[i]));
  end
  task automatic move(int i, int r, int c);
    @(negedge clk);
    mv[i] = 1'b1; mr[i] = 3'(r); mc[i] = 3'(c);
    @(negedge clk);
    mv[i] = 1'b0;
  endtask
  task automatic settle(int i, output int n);
    n = 0;
    while (rdy[i] !== 1'b1 && st[i] == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; fails++;
      $display("FAIL settle_timeout[%0d]: got no exit from check after %0d cycles", i, n);
    end
  endtask
  task automatic play(int i, int r, int c);
    int n;
    move(i, r, c);
    settle(i, n);
  endtask
  task automatic new_game(int i);
    @(negedge clk); ng[i] = 1'b1;
    @(negedge clk); ng[i] = 1'b0;
  endtask
  task automatic sweep_empty(int i);
    for (int r = 0; r < nn(i); r++) for (int c = 0; c < nn(i); c++) begin
      @(negedge clk); rr[i] = 3'(r); rc[i] = 3'(c);
      @(negedge clk); chk("sweep", i, 8'(rdc[i]), 8'd0);
    end
  endtask
  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ng[i] = 1'b0; mv[i] = 1'b0;
      mr[i] = 3'd0; mc[i] = 3'd0; rr[i] = 3'd0; rc[i] = 3'd0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk("rst_ready", 0, 8'(rdy[0]), 8'd1);
    chk("rst_cur", 0, 8'(cur[0]), 8'd1);
    chk("rst_cur", 1, 8'(cur[1]), 8'd2);
    chk("rst_count", 1, 8'(cnt(1)), 8'd0);
    // diagonal win for player 1
    rr[0] = 3'd2; rc[0] = 3'd2;
    play(0, 0, 0); play(0, 0, 1); play(0, 1, 1); play(0, 0, 2);
    move(0, 2, 2);
    settle(0, n);
    chk("win_cycles", 0, 8'(n), 8'd16);
    chk("win_status", 0, 8'(st[0]), 8'd1);
    chk("win_winner", 0, 8'(wn[0]), 8'd1);
    chk("win_count", 0, 8'(cnt(0)), 8'd5);
    chk("win_ready", 0, 8'(rdy[0]), 8'd0);
    chk("win_rd22", 0, 8'(rdc[0]), 8'd1);
    move(0, 1, 0);
    chk("over_err", 0, 8'(er[0]), 8'd1);
    @(negedge clk);
    chk("over_err_pulse", 0, 8'(er[0]), 8'd0);
    // occupied cell and out-of-range row
    new_game(0);
    play(0, 1, 1);
    move(0, 1, 1);
    chk("occ_err", 0, 8'(er[0]), 8'd1);
    chk("occ_count", 0, 8'(cnt(0)), 8'd1);
    chk("occ_cur", 0, 8'(cur[0]), 8'd2);
    move(0, 3, 0);
    chk("oor_err", 0, 8'(er[0]), 8'd1);
    chk("oor_cur", 0, 8'(cur[0]), 8'd2);
    rr[0] = 3'd1; rc[0] = 3'd1;
    repeat (2) @(negedge clk);
    chk("occ_rd11", 0, 8'(rdc[0]), 8'd1);
    // draw: X O X / X O O / O X X
    new_game(0);
    play(0, 0, 0); play(0, 0, 1); play(0, 0, 2); play(0, 1, 1); play(0, 1, 0);
    play(0, 1, 2); play(0, 2, 1); play(0, 2, 0); play(0, 2, 2);
    chk("draw_status", 0, 8'(st[0]), 8'd2);
    chk("draw_winner", 0, 8'(wn[0]), 8'd0);
    chk("draw_count", 0, 8'(cnt(0)), 8'd9);
    move(0, 0, 0);
    chk("draw_err", 0, 8'(er[0]), 8'd1);
    // new_game two cycles into check, colliding with a move
    new_game(0);
    play(0, 0, 0);
    move(0, 1, 1);
    @(negedge clk);
    ng[0] = 1'b1; mv[0] = 1'b1; mr[0] = 3'd2; mc[0] = 3'd2;
    @(negedge clk);
    ng[0] = 1'b0; mv[0] = 1'b0;
    chk("ng_ready", 0, 8'(rdy[0]), 8'd1);
    chk("ng_cur", 0, 8'(cur[0]), 8'd1);
    chk("ng_err", 0, 8'(er[0]), 8'd0);
    chk("ng_count", 0, 8'(cnt(0)), 8'd0);
    sweep_empty(0);
    // move during check, then reset mid-check
    play(0, 0, 0);
    move(0, 2, 2);
    @(negedge clk); mv[0] = 1'b1; mr[0] = 3'd2; mc[0] = 3'd1;
    @(negedge clk); mv[0] = 1'b0;
    chk("check_err", 0, 8'(er[0]), 8'd1);
    rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    chk("rst_mid_count", 0, 8'(cnt(0)), 8'd0);
    repeat (20) @(negedge clk);
    chk("rst_mid_status", 0, 8'(st[0]), 8'd0);
    chk("rst_mid_ready", 0, 8'(rdy[0]), 8'd1);
    // 5x5 K=4 anti-diagonal closed in the middle
    rr[1] = 3'd1; rc[1] = 3'd2;
    play(1, 4, 4); play(1, 0, 3); play(1, 4, 3); play(1, 2, 1); play(1, 4, 1); play(1, 3, 0);
    chk("b_playing", 1, 8'(st[1]), 8'd0);
    chk("b_cur", 1, 8'(cur[1]), 8'd2);
    chk("b_count", 1, 8'(cnt(1)), 8'd6);
    play(1, 3, 4);
    move(1, 1, 2);
    settle(1, n);
    chk("b_win_cycles", 1, 8'(n), 8'd24);
    chk("b_win_status", 1, 8'(st[1]), 8'd1);
    chk("b_win_winner", 1, 8'(wn[1]), 8'd1);
    chk("b_win_count", 1, 8'(cnt(1)), 8'd8);
    // reset while over with FIRST=2
    @(negedge clk); rst[1] = 1'b1;
    @(negedge clk); rst[1] = 1'b0;
    chk("b_rst_cur", 1, 8'(cur[1]), 8'd2);
    chk("b_rst_count", 1, 8'(cnt(1)), 8'd0);
    chk("b_rst_status", 1, 8'(st[1]), 8'd0);
    chk("b_rst_ready", 1, 8'(rdy[1]), 8'd1);
    chk("b_rst_rd", 1, 8'(rdc[1]), 8'd0);
    sweep_empty(1);
    @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
